fwd_source_pipe: RTL and testbench

FWD_SOURCE_PIPE -- requirements
Module: fwd_source_pipe

---
 rtl/fwd_source_pipe_pkg.sv | 35 +++
 rtl/fwd_source_pipe_if.sv | 45 ++++
 rtl/fwd_source_pipe_slot.sv | 47 ++++
 rtl/fwd_source_pipe.sv | 96 +++++++++
 tb/tb_fwd_source_pipe.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/fwd_source_pipe_pkg.sv
// Shared types and constants for the EX/MEM and MEM/WB forwarding-source pipeline.
// Also holds the operand-select encoding consumed by the downstream forwarding unit.
package fwd_source_pipe_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  // The younger EX/MEM producer wins over MEM/WB; x0 is never forwarded.
  function automatic fwd_sel_e fwd_select(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  exmem_regwrite,
    input logic [REG_ADDR_W-1:0] exmem_rd,
    input logic                  memwb_regwrite,
    input logic [REG_ADDR_W-1:0] memwb_rd
  );
    fwd_sel_e sel;
    sel = FWD_NONE;
    if (rs != REG_X0) begin
      if (exmem_regwrite && (exmem_rd == rs)) begin
        sel = FWD_EXMEM;
      end else if (memwb_regwrite && (memwb_rd == rs)) begin
        sel = FWD_MEMWB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_source_pipe_if.sv
// EX-stage offer, load response, forwarding sources and register-file write port.
// The pipeline is the slave side; whoever feeds EX and the memory is the master.
interface fwd_source_pipe_if
  import fwd_source_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic                  ex_valid;
  logic                  ex_regwrite;
  logic                  ex_memread;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [XLEN-1:0]       ex_result;
  logic                  ex_flush;
  logic                  ex_ready;
  logic                  mem_rsp_valid;
  logic [XLEN-1:0]       mem_rsp_data;
  logic                  exmem_regwrite;
  logic [REG_ADDR_W-1:0] exmem_rd;
  logic [XLEN-1:0]       exmem_result;
  logic                  memwb_regwrite;
  logic [REG_ADDR_W-1:0] memwb_rd;
  logic [XLEN-1:0]       memwb_result;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]       rf_wdata;
  logic                  rsp_err;

  modport master (
    output ex_valid, ex_regwrite, ex_memread, ex_rd, ex_result, ex_flush,
    output mem_rsp_valid, mem_rsp_data,
    input  ex_ready, exmem_regwrite, exmem_rd, exmem_result,
    input  memwb_regwrite, memwb_rd, memwb_result,
    input  rf_we, rf_waddr, rf_wdata, rsp_err
  );

  modport slave (
    input  ex_valid, ex_regwrite, ex_memread, ex_rd, ex_result, ex_flush,
    input  mem_rsp_valid, mem_rsp_data,
    output ex_ready, exmem_regwrite, exmem_rd, exmem_result,
    output memwb_regwrite, memwb_rd, memwb_result,
    output rf_we, rf_waddr, rf_wdata, rsp_err
  );

endinterface

// File: rtl/fwd_source_pipe_slot.sv
// One pipeline slot: valid/regwrite/rd/data register.
// Load wins over clear; with neither asserted the slot holds its contents.
module pipe_slot
  import fwd_source_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  clear,
  input  logic                  new_regwrite,
  input  logic [REG_ADDR_W-1:0] new_rd,
  input  logic [XLEN-1:0]       new_data,
  output logic                  valid,
  output logic                  regwrite,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       data
);

  logic                  valid_reg;
  logic                  regwrite_reg;
  logic [REG_ADDR_W-1:0] rd_reg;
  logic [XLEN-1:0]       data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      rd_reg       <= '0;
      data_reg     <= '0;
    end else if (load) begin
      valid_reg    <= 1'b1;
      regwrite_reg <= new_regwrite;
      rd_reg       <= new_rd;
      data_reg     <= new_data;
    end else if (clear) begin
      valid_reg    <= 1'b0;
    end
  end

  assign valid    = valid_reg;
  assign regwrite = regwrite_reg;
  assign rd       = rd_reg;
  assign data     = data_reg;

endmodule

// File: rtl/fwd_source_pipe.sv
// EX/MEM and MEM/WB slots acting as forwarding sources, with a variable-latency
// load stall in EX/MEM and write-back driven straight from MEM/WB.
module fwd_source_pipe
  import fwd_source_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  fwd_source_pipe_if.slave   bus
);

  logic                  exmem_valid;
  logic                  exmem_rw;
  logic                  exmem_memread_reg;
  logic [REG_ADDR_W-1:0] exmem_rd;
  logic [XLEN-1:0]       exmem_data;
  logic                  memwb_valid;
  logic                  memwb_rw;
  logic [REG_ADDR_W-1:0] memwb_rd;
  logic [XLEN-1:0]       memwb_data;
  logic                  rsp_err_reg;

  logic                  load_pending;
  logic                  capture;
  logic                  exmem_hold;
  logic                  exmem_clear;
  logic                  memwb_load;
  logic [XLEN-1:0]       memwb_new_data;

  // ex_ready depends only on registered state, never on mem_rsp_valid.
  assign load_pending   = exmem_valid & exmem_memread_reg;
  assign capture        = bus.ex_valid & ~load_pending & ~bus.ex_flush;
  assign exmem_hold     = load_pending & ~bus.mem_rsp_valid;
  assign exmem_clear    = ~capture & ~exmem_hold;
  assign memwb_load     = exmem_valid & (~exmem_memread_reg | bus.mem_rsp_valid);
  assign memwb_new_data = exmem_memread_reg ? bus.mem_rsp_data : exmem_data;

  pipe_slot #(.XLEN(XLEN)) u_exmem (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (capture),
    .clear        (exmem_clear),
    .new_regwrite (bus.ex_regwrite & (bus.ex_rd != REG_X0)),
    .new_rd       (bus.ex_rd),
    .new_data     (bus.ex_result),
    .valid        (exmem_valid),
    .regwrite     (exmem_rw),
    .rd           (exmem_rd),
    .data         (exmem_data)
  );

  pipe_slot #(.XLEN(XLEN)) u_memwb (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (memwb_load),
    .clear        (~memwb_load),
    .new_regwrite (exmem_rw),
    .new_rd       (exmem_rd),
    .new_data     (memwb_new_data),
    .valid        (memwb_valid),
    .regwrite     (memwb_rw),
    .rd           (memwb_rd),
    .data         (memwb_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_memread_reg <= 1'b0;
      rsp_err_reg       <= 1'b0;
    end else begin
      if (capture) begin
        exmem_memread_reg <= bus.ex_memread;
      end else if (exmem_clear) begin
        exmem_memread_reg <= 1'b0;
      end
      // A response with nothing outstanding is a protocol error; it latches until reset.
      if (bus.mem_rsp_valid && !load_pending) begin
        rsp_err_reg <= 1'b1;
      end
    end
  end

  assign bus.ex_ready       = ~load_pending;
  assign bus.exmem_regwrite = exmem_valid & exmem_rw & ~exmem_memread_reg;
  assign bus.exmem_rd       = exmem_rd;
  assign bus.exmem_result   = exmem_data;
  assign bus.memwb_regwrite = memwb_valid & memwb_rw;
  assign bus.memwb_rd       = memwb_rd;
  assign bus.memwb_result   = memwb_data;
  assign bus.rf_we          = memwb_valid & memwb_rw;
  assign bus.rf_waddr       = memwb_rd;
  assign bus.rf_wdata       = memwb_data;
  assign bus.rsp_err        = rsp_err_reg;

endmodule

// File: tb/tb_fwd_source_pipe.sv
// Directed vector table for fwd_source_pipe plus hand-written reset and
// stray-response sequences.
module tb_fwd_source_pipe;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  fwd_source_pipe_if bus_if ();

  fwd_source_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, rw, mr;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        fl, rv;
    logic [31:0] rdata;
    logic        e_xrw;
    logic [4:0]  e_xrd;
    logic [31:0] e_xres;
    logic        e_mrw;
    logic [4:0]  e_mrd;
    logic [31:0] e_mres;
    logic        e_rdy, e_err;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic v, rw, mr, input logic [4:0] rd, input logic [31:0] res,
    input logic fl, rv, input logic [31:0] rdata,
    input logic xrw, input logic [4:0] xrd, input logic [31:0] xres,
    input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
    input logic rdy, err
  );
    vec_t t;
    t.v = v; t.rw = rw; t.mr = mr; t.rd = rd; t.res = res;
    t.fl = fl; t.rv = rv; t.rdata = rdata;
    t.e_xrw = xrw; t.e_xrd = xrd; t.e_xres = xres;
    t.e_mrw = mrw; t.e_mrd = mrd; t.e_mres = mres;
    t.e_rdy = rdy; t.e_err = err;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, rw, mr, input logic [4:0] rd, input logic [31:0] res,
                       input logic fl, rv, input logic [31:0] rdata);
    bus_if.ex_valid      = v;
    bus_if.ex_regwrite   = rw;
    bus_if.ex_memread    = mr;
    bus_if.ex_rd         = rd;
    bus_if.ex_result     = res;
    bus_if.ex_flush      = fl;
    bus_if.mem_rsp_valid = rv;
    bus_if.mem_rsp_data  = rdata;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    idle();

    //              v  rw mr rd     res          fl rv rdata         xrw xrd    xres         mrw mrd   mres          rdy err
    vecs[0]  = mk(1, 1, 0, 5'd5,  32'h11,      0, 0, 32'h0,        1, 5'd5,  32'h11,      0, 5'd0, 32'h0,        1, 0);
    vecs[1]  = mk(1, 1, 0, 5'd6,  32'h22,      0, 0, 32'h0,        1, 5'd6,  32'h22,      1, 5'd5, 32'h11,       1, 0);
    vecs[2]  = mk(0, 0, 0, 5'd0,  32'h0,       0, 0, 32'h0,        0, 5'd0,  32'h0,       1, 5'd6, 32'h22,       1, 0);
    vecs[3]  = mk(0, 0, 0, 5'd0,  32'h0,       0, 0, 32'h0,        0, 5'd0,  32'h0,       0, 5'd0, 32'h0,        1, 0);
    vecs[4]  = mk(1, 1, 0, 5'd0,  32'h55,      0, 0, 32'h0,        0, 5'd0,  32'h0,       0, 5'd0, 32'h0,        1, 0);
    vecs[5]  = mk(0, 0, 0, 5'd0,  32'h0,       0, 0, 32'h0,        0, 5'd0,  32'h0,       0, 5'd0, 32'h0,        1, 0);
    vecs[6]  = mk(1, 1, 0, 5'd9,  32'h99,      1, 0, 32'h0,        0, 5'd0,  32'h0,       0, 5'd0, 32'h0,        1, 0);
    vecs[7]  = mk(0, 0, 0, 5'd0,  32'h0,       0, 0, 32'h0,        0, 5'd0,  32'h0,       0, 5'd0, 32'h0,        1, 0);
    vecs[8]  = mk(1, 1, 1, 5'd7,  32'h0,       0, 0, 32'h0,        0, 5'd0,  32'h0,       0, 5'd0, 32'h0,        0, 0);
    vecs[9]  = mk(1, 1, 0, 5'd3,  32'h33,      0, 0, 32'h0,        0, 5'd0,  32'h0,       0, 5'd0, 32'h0,        0, 0);
    vecs[10] = mk(0, 0, 0, 5'd0,  32'h0,       0, 0, 32'h0,        0, 5'd0,  32'h0,       0, 5'd0, 32'h0,        0, 0);
    vecs[11] = mk(0, 0, 0, 5'd0,  32'h0,       0, 1, 32'hDEADBEEF, 0, 5'd0,  32'h0,       1, 5'd7, 32'hDEADBEEF, 1, 0);
    vecs[12] = mk(0, 0, 0, 5'd0,  32'h0,       0, 0, 32'h0,        0, 5'd0,  32'h0,       0, 5'd0, 32'h0,        1, 0);
    vecs[13] = mk(1, 1, 0, 5'd10, 32'hA5A5,    0, 0, 32'h0,        1, 5'd10, 32'hA5A5,    0, 5'd0, 32'h0,        1, 0);
    vecs[14] = mk(1, 0, 0, 5'd11, 32'h77,      0, 0, 32'h0,        0, 5'd0,  32'h0,       1, 5'd10, 32'hA5A5,    1, 0);
    vecs[15] = mk(0, 0, 0, 5'd0,  32'h0,       0, 0, 32'h0,        0, 5'd0,  32'h0,       0, 5'd0, 32'h0,        1, 0);

    // Reset state, sampled while reset is held.
    @(posedge clk); #1;
    chk("rst_ex_ready",       bus_if.ex_ready,       1);
    chk("rst_exmem_regwrite", bus_if.exmem_regwrite, 0);
    chk("rst_memwb_regwrite", bus_if.memwb_regwrite, 0);
    chk("rst_rf_we",          bus_if.rf_we,          0);
    chk("rst_rsp_err",        bus_if.rsp_err,        0);
    chk("rst_exmem_rd",       bus_if.exmem_rd,       0);
    chk("rst_exmem_result",   bus_if.exmem_result,   0);
    chk("rst_memwb_rd",       bus_if.memwb_rd,       0);
    chk("rst_memwb_result",   bus_if.memwb_result,   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].rw, vecs[i].mr, vecs[i].rd, vecs[i].res,
            vecs[i].fl, vecs[i].rv, vecs[i].rdata);
      @(posedge clk); #1;
      $display("vec %0d: exmem rw=%0b rd=%0d memwb rw=%0b rd=%0d res=%h ready=%0b err=%0b",
               i, bus_if.exmem_regwrite, bus_if.exmem_rd, bus_if.memwb_regwrite,
               bus_if.memwb_rd, bus_if.memwb_result, bus_if.ex_ready, bus_if.rsp_err);
      chk($sformatf("v%0d_exmem_regwrite", i), bus_if.exmem_regwrite, vecs[i].e_xrw);
      chk($sformatf("v%0d_memwb_regwrite", i), bus_if.memwb_regwrite, vecs[i].e_mrw);
      chk($sformatf("v%0d_rf_we", i),          bus_if.rf_we,          vecs[i].e_mrw);
      chk($sformatf("v%0d_ex_ready", i),       bus_if.ex_ready,       vecs[i].e_rdy);
      chk($sformatf("v%0d_rsp_err", i),        bus_if.rsp_err,        vecs[i].e_err);
      if (vecs[i].e_xrw) begin
        chk($sformatf("v%0d_exmem_rd", i),     bus_if.exmem_rd,     vecs[i].e_xrd);
        chk($sformatf("v%0d_exmem_result", i), bus_if.exmem_result, vecs[i].e_xres);
      end
      if (vecs[i].e_mrw) begin
        chk($sformatf("v%0d_memwb_rd", i),     bus_if.memwb_rd,     vecs[i].e_mrd);
        chk($sformatf("v%0d_memwb_result", i), bus_if.memwb_result, vecs[i].e_mres);
        chk($sformatf("v%0d_rf_waddr", i),     bus_if.rf_waddr,     vecs[i].e_mrd);
        chk($sformatf("v%0d_rf_wdata", i),     bus_if.rf_wdata,     vecs[i].e_mres);
      end
    end

    // Stray response on an idle pipe: error latches, no write-back.
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h1234);
    @(posedge clk); #1;
    $display("stray rsp: err=%0b memwb_rw=%0b", bus_if.rsp_err, bus_if.memwb_regwrite);
    chk("stray_rsp_err",       bus_if.rsp_err,        1);
    chk("stray_memwb_regwrite",bus_if.memwb_regwrite, 0);
    chk("stray_rf_we",         bus_if.rf_we,          0);
    idle();
    @(posedge clk); #1;
    $display("after stray: err=%0b", bus_if.rsp_err);
    chk("sticky_rsp_err",      bus_if.rsp_err,        1);
    chk("sticky_memwb_regwrite", bus_if.memwb_regwrite, 0);

    // Reset while a load is pending: load abandoned, later response is stray.
    drive(1'b1, 1'b1, 1'b1, 5'd8, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    idle();
    chk("midload_ex_ready_low", bus_if.ex_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    $display("midload reset: ready=%0b err=%0b", bus_if.ex_ready, bus_if.rsp_err);
    chk("midrst_ex_ready",       bus_if.ex_ready,       1);
    chk("midrst_exmem_regwrite", bus_if.exmem_regwrite, 0);
    chk("midrst_memwb_regwrite", bus_if.memwb_regwrite, 0);
    chk("midrst_rf_we",          bus_if.rf_we,          0);
    chk("midrst_rsp_err",        bus_if.rsp_err,        0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_ex_ready", bus_if.ex_ready, 1);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'hBAD0BAD0);
    @(posedge clk); #1;
    idle();
    $display("late rsp: err=%0b memwb_rw=%0b rf_we=%0b", bus_if.rsp_err, bus_if.memwb_regwrite, bus_if.rf_we);
    chk("late_rsp_err",        bus_if.rsp_err,        1);
    chk("late_memwb_regwrite", bus_if.memwb_regwrite, 0);
    chk("late_rf_we",          bus_if.rf_we,          0);
    chk("late_ex_ready",       bus_if.ex_ready,       1);
    @(posedge clk); #1;
    chk("late_rf_we_next",     bus_if.rf_we,          0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
